// File: rtl/seg_bcd_sched.sv
// seg_bcd_sched: one serial shift-add-3 BCD converter shared by two
// requesters, plus a 4-digit multiplexed 7-segment scanner.
module seg_bcd_sched #(
    parameter int DIV_BITS = 18
) (
    input  logic       clk_50mHz,
    input  logic       rst,
    input  logic       req0,
    input  logic [7:0] val0,
    input  logic       req1,
    input  logic [7:0] val1,
    output logic       ack0,
    output logic       ack1,
    output logic       busy,
    input  logic       disp_sel,
    output logic [6:0] a_to_g,
    output logic [3:0] an
);

    localparam int CW = DIV_BITS + 2;

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_SHIFT,
        S_STORE
    } state_t;

    state_t      r_state;
    state_t      w_next;

    logic        r_gnt;
    logic        r_last;
    logic        w_req_any;
    logic        w_pick;

    logic [17:0] r_sr;
    logic [17:0] w_adj;
    logic [2:0]  r_cnt;

    logic [9:0]  r_bcd0;
    logic [9:0]  r_bcd1;

    logic        w_load;
    logic        w_shift;
    logic        w_store;

    logic [CW-1:0] r_scan;
    logic [1:0]    w_slot;
    logic [9:0]    w_bcd;
    logic [3:0]    w_digit;
    logic          w_blank;
    logic [6:0]    w_seg;

    // Arbitration: a lone request wins; a tie goes to the channel not served last.
    always_comb begin
        w_req_any = req0 | req1;
        w_pick    = (req0 & req1) ? ~r_last : req1;
    end

    // State register.
    always_ff @(posedge clk_50mHz) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic: one LOAD, eight SHIFTs, one STORE per conversion.
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (w_req_any) begin
                    w_next = S_LOAD;
                end
            end
            S_LOAD: begin
                w_next = S_SHIFT;
            end
            S_SHIFT: begin
                if (r_cnt == 3'd7) begin
                    w_next = S_STORE;
                end
            end
            S_STORE: begin
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // Moore outputs decoded from the current state.
    always_comb begin
        w_load  = (r_state == S_LOAD);
        w_shift = (r_state == S_SHIFT);
        w_store = (r_state == S_STORE);
        busy    = (r_state != S_IDLE);
        ack0    = w_load & ~r_gnt;
        ack1    = w_load & r_gnt;
    end

    // Grant and fairness memory update only when a grant is issued from IDLE.
    always_ff @(posedge clk_50mHz) begin
        if (rst) begin
            r_gnt  <= 1'b0;
            r_last <= 1'b1;
        end else if ((r_state == S_IDLE) && w_req_any) begin
            r_gnt  <= w_pick;
            r_last <= w_pick;
        end
    end

    // Add-3 correction on the ones and tens nibbles before each shift.
    always_comb begin
        w_adj = r_sr;
        if (r_sr[11:8] >= 4'd5) begin
            w_adj[11:8] = r_sr[11:8] + 4'd3;
        end
        if (r_sr[15:12] >= 4'd5) begin
            w_adj[15:12] = r_sr[15:12] + 4'd3;
        end
    end

    // Converter shift register and shift counter.
    always_ff @(posedge clk_50mHz) begin
        if (rst) begin
            r_sr  <= '0;
            r_cnt <= '0;
        end else if (w_load) begin
            r_sr  <= {10'b0, (r_gnt ? val1 : val0)};
            r_cnt <= '0;
        end else if (w_shift) begin
            r_sr  <= w_adj << 1;
            r_cnt <= r_cnt + 3'd1;
        end
    end

    // Per-channel result registers written in STORE.
    always_ff @(posedge clk_50mHz) begin
        if (rst) begin
            r_bcd0 <= '0;
            r_bcd1 <= '0;
        end else if (w_store) begin
            if (r_gnt) begin
                r_bcd1 <= r_sr[17:8];
            end else begin
                r_bcd0 <= r_sr[17:8];
            end
        end
    end

    // Free-running scan counter; the top two bits select the digit slot.
    always_ff @(posedge clk_50mHz) begin
        if (rst) begin
            r_scan <= '0;
        end else begin
            r_scan <= r_scan + {{(CW-1){1'b0}}, 1'b1};
        end
    end

    // Digit selection with leading-zero blanking on tens and hundreds.
    always_comb begin
        w_slot  = r_scan[CW-1 -: 2];
        w_bcd   = disp_sel ? r_bcd1 : r_bcd0;
        w_digit = 4'd0;
        w_blank = 1'b1;
        an      = 4'b1111;
        unique case (w_slot)
            2'd0: begin
                w_digit = w_bcd[3:0];
                w_blank = 1'b0;
                an      = 4'b1110;
            end
            2'd1: begin
                w_digit = w_bcd[7:4];
                w_blank = (w_bcd[9:8] == 2'd0) && (w_bcd[7:4] == 4'd0);
                an      = w_blank ? 4'b1111 : 4'b1101;
            end
            2'd2: begin
                w_digit = {2'b00, w_bcd[9:8]};
                w_blank = (w_bcd[9:8] == 2'd0);
                an      = w_blank ? 4'b1111 : 4'b1011;
            end
            default: begin
                w_digit = 4'd0;
                w_blank = 1'b1;
                an      = 4'b1111;
            end
        endcase
    end

    // Active-low segment decode; illegal codes fall back to "0".
    always_comb begin
        unique case (w_digit)
            4'd0:    w_seg = 7'b0000001;
            4'd1:    w_seg = 7'b1001111;
            4'd2:    w_seg = 7'b0010010;
            4'd3:    w_seg = 7'b0000110;
            4'd4:    w_seg = 7'b1001100;
            4'd5:    w_seg = 7'b0100100;
            4'd6:    w_seg = 7'b0100000;
            4'd7:    w_seg = 7'b0001111;
            4'd8:    w_seg = 7'b0000000;
            4'd9:    w_seg = 7'b0000100;
            default: w_seg = 7'b0000001;
        endcase
        a_to_g = w_blank ? 7'b1111111 : w_seg;
    end

endmodule

// File: tb/tb_seg_bcd_sched.sv
// tb_seg_bcd_sched: directed vectors and timing sequences for the
// shared BCD converter and display scanner.
module tb_seg_bcd_sched;

    localparam int DIV_BITS = 2;
    localparam int SCAN = 1 << (DIV_BITS + 2);
    localparam logic [6:0] BL = 7'b1111111;
    localparam logic [6:0] S0 = 7'b0000001;
    localparam logic [6:0] S1 = 7'b1001111;
    localparam logic [6:0] S2 = 7'b0010010;
    localparam logic [6:0] S3 = 7'b0000110;
    localparam logic [6:0] S4 = 7'b1001100;
    localparam logic [6:0] S5 = 7'b0100100;
    localparam logic [6:0] S6 = 7'b0100000;
    localparam logic [6:0] S7 = 7'b0001111;
    localparam logic [6:0] S8 = 7'b0000000;
    localparam logic [6:0] S9 = 7'b0000100;

    logic       clk_50mHz = 1'b0;
    logic       rst = 1'b1;
    logic       req0 = 1'b0;
    logic [7:0] val0 = 8'd0;
    logic       req1 = 1'b0;
    logic [7:0] val1 = 8'd0;
    logic       ack0;
    logic       ack1;
    logic       busy;
    logic       disp_sel = 1'b0;
    logic [6:0] a_to_g;
    logic [3:0] an;

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic [7:0] val;
        logic [6:0] one;
        logic [6:0] ten;
        logic [6:0] hun;
    } vec_t;

    vec_t tbl[8];

    seg_bcd_sched #(.DIV_BITS(DIV_BITS)) dut (
        .clk_50mHz(clk_50mHz),
        .rst(rst),
        .req0(req0),
        .val0(val0),
        .req1(req1),
        .val1(val1),
        .ack0(ack0),
        .ack1(ack1),
        .busy(busy),
        .disp_sel(disp_sel),
        .a_to_g(a_to_g),
        .an(an)
    );

    always #5 clk_50mHz = ~clk_50mHz;

    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk_50mHz);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req0 = 1'b0;
        req1 = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    // Watch one full scan; capture segments per enabled digit.
    task automatic check_disp(input string nm, input logic [6:0] e_one,
                              input logic [6:0] e_ten, input logic [6:0] e_hun);
        logic [6:0] seg [3];
        logic [2:0] en;
        logic       an3;
        logic [6:0] ex [3];
        ex[0] = e_one;
        ex[1] = e_ten;
        ex[2] = e_hun;
        en = 3'b000;
        an3 = 1'b0;
        for (int k = 0; k < 3; k++) seg[k] = BL;
        for (int c = 0; c < SCAN; c++) begin
            tick();
            if (an == 4'b1110) begin en[0] = 1'b1; seg[0] = a_to_g; end
            if (an == 4'b1101) begin en[1] = 1'b1; seg[1] = a_to_g; end
            if (an == 4'b1011) begin en[2] = 1'b1; seg[2] = a_to_g; end
            if (an[3] == 1'b0) an3 = 1'b1;
        end
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("%s dig%0d_en", nm, k), 32'(en[k]), 32'(ex[k] != BL));
            if (ex[k] != BL)
                chk($sformatf("%s dig%0d_seg", nm, k), 32'(seg[k]), 32'(ex[k]));
        end
        chk($sformatf("%s an3_blank", nm), 32'(an3), 32'd0);
    endtask

    task automatic wait_idle(input string nm);
        int n;
        n = 0;
        while (busy && n < 30) begin
            tick();
            n++;
        end
        chk($sformatf("%s idle_timeout", nm), 32'(busy), 32'd0);
    endtask

    task automatic convert0(input string nm, input logic [7:0] v);
        int n;
        val0 = v;
        req0 = 1'b1;
        n = 0;
        do begin
            tick();
            n++;
        end while (!ack0 && n < 30);
        chk($sformatf("%s ack0_seen", nm), 32'(ack0), 32'd1);
        req0 = 1'b0;
        wait_idle(nm);
    endtask

    initial begin
        int a_cyc[8];
        int a_ch[8];
        int na;
        int dbl;
        int na1;

        tbl[0] = '{8'd0,   S0, BL, BL};
        tbl[1] = '{8'd9,   S9, BL, BL};
        tbl[2] = '{8'd10,  S0, S1, BL};
        tbl[3] = '{8'd99,  S9, S9, BL};
        tbl[4] = '{8'd128, S8, S2, S1};
        tbl[5] = '{8'd200, S0, S0, S2};
        tbl[6] = '{8'd64,  S4, S6, BL};
        tbl[7] = '{8'd137, S7, S3, S1};

        // Reset state.
        do_reset();
        chk("rst busy", 32'(busy), 32'd0);
        chk("rst ack0", 32'(ack0), 32'd0);
        chk("rst ack1", 32'(ack1), 32'd0);
        chk("rst an", 32'(an), 32'b1110);
        chk("rst seg", 32'(a_to_g), 32'(S0));
        check_disp("rst", S0, BL, BL);

        // Single conversion timing for 255.
        disp_sel = 1'b0;
        val0 = 8'd255;
        req0 = 1'b1;
        for (int i = 1; i <= 12; i++) begin
            tick();
            chk($sformatf("t255 ack0@%0d", i), 32'(ack0), 32'(i == 1));
            chk($sformatf("t255 ack1@%0d", i), 32'(ack1), 32'd0);
            chk($sformatf("t255 busy@%0d", i), 32'(busy),
                32'((i >= 1) && (i <= 10)));
            if (i == 1) req0 = 1'b0;
        end
        check_disp("v255", S5, S5, S2);

        // Table of single conversions on channel 0.
        for (int v = 0; v < 8; v++) begin
            convert0($sformatf("tbl%0d", v), tbl[v].val);
            check_disp($sformatf("tbl%0d", v), tbl[v].one, tbl[v].ten, tbl[v].hun);
        end

        // Tie right after reset: channel 0 first, channel 1 eleven cycles later.
        do_reset();
        val0 = 8'd100;
        val1 = 8'd7;
        req0 = 1'b1;
        req1 = 1'b1;
        for (int i = 1; i <= 14; i++) begin
            tick();
            chk($sformatf("tie ack0@%0d", i), 32'(ack0), 32'(i == 1));
            chk($sformatf("tie ack1@%0d", i), 32'(ack1), 32'(i == 12));
            if (ack0) req0 = 1'b0;
            if (ack1) req1 = 1'b0;
        end
        wait_idle("tie");
        disp_sel = 1'b0;
        check_disp("tie ch0", S0, S0, S1);
        disp_sel = 1'b1;
        check_disp("tie ch1", S7, BL, BL);

        // Fairness with both requests held for 50 cycles.
        do_reset();
        val0 = 8'd33;
        val1 = 8'd58;
        req0 = 1'b1;
        req1 = 1'b1;
        na = 0;
        dbl = 0;
        for (int i = 1; i <= 50; i++) begin
            tick();
            if (ack0 && ack1) dbl++;
            if ((ack0 || ack1) && na < 8) begin
                a_cyc[na] = i;
                a_ch[na] = ack1 ? 1 : 0;
                na++;
            end
        end
        req0 = 1'b0;
        req1 = 1'b0;
        wait_idle("fair");
        chk("fair n_acks", 32'(na), 32'd5);
        chk("fair double", 32'(dbl), 32'd0);
        for (int j = 0; j < na; j++) begin
            chk($sformatf("fair ch%0d", j), 32'(a_ch[j]), 32'(j % 2));
            chk($sformatf("fair cyc%0d", j), 32'(a_cyc[j]), 32'(1 + 11 * j));
        end

        // Request pulsed while busy is dropped.
        val0 = 8'd5;
        req0 = 1'b1;
        na1 = 0;
        for (int i = 1; i <= 25; i++) begin
            tick();
            if (ack1) na1++;
            if (i == 1) req0 = 1'b0;
            if (i == 3) begin
                val1 = 8'd99;
                req1 = 1'b1;
            end
            if (i == 4) req1 = 1'b0;
        end
        chk("wd ack1_count", 32'(na1), 32'd0);
        disp_sel = 1'b1;
        check_disp("wd ch1", S8, S5, BL);
        disp_sel = 1'b0;
        check_disp("wd ch0", S5, BL, BL);

        // Reset in the middle of SHIFT abandons the conversion.
        val0 = 8'd42;
        req0 = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            tick();
            if (i == 1) req0 = 1'b0;
            if (i == 5) chk("mid busy@5", 32'(busy), 32'd1);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mid busy@6", 32'(busy), 32'd0);
        chk("mid ack0@6", 32'(ack0), 32'd0);
        for (int i = 7; i <= 12; i++) begin
            tick();
            chk($sformatf("mid busy@%0d", i), 32'(busy), 32'd0);
        end
        check_disp("mid cleared", S0, BL, BL);
        convert0("mid redo", 8'd42);
        check_disp("mid 42", S2, S4, BL);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
